// File: rtl/scalar_issue_scheduler_pkg.sv
// Shared opcodes, unit codes, latencies and bundle types for the
// scalar issue scheduler and its write-back timing chain.
package scalar_issue_scheduler_pkg;

    localparam logic [6:0] OP_SMASKR = 7'o042;
    localparam logic [6:0] OP_SMASKL = 7'o043;
    localparam logic [6:0] OP_SAND   = 7'o044;
    localparam logic [6:0] OP_SANDC  = 7'o045;
    localparam logic [6:0] OP_SOR    = 7'o046;
    localparam logic [6:0] OP_SXOR   = 7'o047;
    localparam logic [6:0] OP_SMERGE = 7'o050;
    localparam logic [6:0] OP_SEQV   = 7'o051;
    localparam logic [6:0] OP_SSHL   = 7'o054;
    localparam logic [6:0] OP_SSHR   = 7'o055;
    localparam logic [6:0] OP_SDSHL  = 7'o056;
    localparam logic [6:0] OP_SDSHR  = 7'o057;
    localparam logic [6:0] OP_SADD   = 7'o060;
    localparam logic [6:0] OP_SADD1  = 7'o061;

    localparam logic [1:0] UNIT_LOG = 2'd0;
    localparam logic [1:0] UNIT_SHF = 2'd1;
    localparam logic [1:0] UNIT_ADD = 2'd2;

    localparam int DEF_LAT_LOGICAL = 1;
    localparam int DEF_LAT_SHIFT   = 2;
    localparam int DEF_LAT_DSHIFT  = 3;
    localparam int DEF_LAT_ADD     = 3;
    localparam int DEF_MAX_LAT     = 4;

    // Latency class; the scheduler maps it onto its LAT_* parameters.
    localparam logic [1:0] LC_LOG  = 2'd0;
    localparam logic [1:0] LC_SHF  = 2'd1;
    localparam logic [1:0] LC_DSHF = 2'd2;
    localparam logic [1:0] LC_ADD  = 2'd3;

    typedef struct packed {
        logic       v;
        logic [2:0] i;
        logic [1:0] unit;
    } wb_slot_t;

    typedef struct packed {
        logic       claimed;
        logic [1:0] unit;
        logic [1:0] lcls;
        logic       rd_i;
        logic       rd_j;
        logic       rd_k;
    } dec_t;

    // j=0 / k=0 select constants, so they never take part in hazards.
    function automatic dec_t decode(input logic [6:0] op,
                                    input logic [2:0] j,
                                    input logic [2:0] k);
        dec_t d;
        d = '0;
        unique case (op)
            OP_SMASKR, OP_SMASKL: begin
                d.claimed = 1'b1;
                d.unit    = UNIT_LOG;
                d.lcls    = LC_LOG;
            end
            OP_SAND, OP_SANDC, OP_SOR, OP_SXOR, OP_SEQV: begin
                d.claimed = 1'b1;
                d.unit    = UNIT_LOG;
                d.lcls    = LC_LOG;
                d.rd_j    = (j != 3'd0);
                d.rd_k    = (k != 3'd0);
            end
            OP_SMERGE: begin
                d.claimed = 1'b1;
                d.unit    = UNIT_LOG;
                d.lcls    = LC_LOG;
                d.rd_i    = 1'b1;
                d.rd_j    = (j != 3'd0);
                d.rd_k    = (k != 3'd0);
            end
            OP_SSHL, OP_SSHR: begin
                d.claimed = 1'b1;
                d.unit    = UNIT_SHF;
                d.lcls    = LC_SHF;
                d.rd_i    = 1'b1;
            end
            OP_SDSHL, OP_SDSHR: begin
                d.claimed = 1'b1;
                d.unit    = UNIT_SHF;
                d.lcls    = LC_DSHF;
                d.rd_i    = 1'b1;
                d.rd_j    = (j != 3'd0);
            end
            OP_SADD, OP_SADD1: begin
                d.claimed = 1'b1;
                d.unit    = UNIT_ADD;
                d.lcls    = LC_ADD;
                d.rd_j    = (j != 3'd0);
                d.rd_k    = (k != 3'd0);
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/scalar_issue_scheduler_if.sv
// Issue handshake between the instruction buffer (master) and the
// scalar issue scheduler (slave): opcode, designators, valid/ready.
interface scalar_issue_scheduler_if;

    logic       i_issue_valid;
    logic [6:0] i_instr;
    logic [2:0] i_i;
    logic [2:0] i_j;
    logic [2:0] i_k;
    logic       o_issue_ready;

    modport master (
        output i_issue_valid, i_instr, i_i, i_j, i_k,
        input  o_issue_ready
    );

    modport slave (
        input  i_issue_valid, i_instr, i_i, i_j, i_k,
        output o_issue_ready
    );

endinterface

// File: rtl/scalar_wb_chain.sv
// Write-port timing chain: DEPTH slots shifting toward slot 0 each edge.
// Ports: clk, rst, ins_en/ins_idx/ins_slot (insert), slot_v (occupancy), head (slot 0).
module scalar_wb_chain
    import scalar_issue_scheduler_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_LAT,
    parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ins_en,
    input  logic [IW-1:0]    ins_idx,
    input  wb_slot_t         ins_slot,
    output logic [DEPTH-1:0] slot_v,
    output wb_slot_t         head
);

    wb_slot_t slots [DEPTH];

    // Insert is applied after the shift; the caller's port check
    // guarantees the shifted-in entry at ins_idx is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < DEPTH; n++) begin
                slots[n] <= '0;
            end
        end else begin
            for (int n = 0; n < DEPTH - 1; n++) begin
                slots[n] <= slots[n+1];
            end
            slots[DEPTH-1] <= '0;
            if (ins_en) begin
                slots[ins_idx] <= ins_slot;
            end
        end
    end

    always_comb begin
        slot_v = '0;
        for (int n = 0; n < DEPTH; n++) begin
            slot_v[n] = slots[n].v;
        end
    end

    assign head = slots[0];

endmodule

// File: rtl/scalar_issue_scheduler.sv
// Issue sequencer for scalar logical/shift/add units with S-register
// reservation bits and a write-port timing chain.
// Ports: clk, rst, iss (issue handshake), i_ext_busy, o_stall_src/dst/port,
//        o_fu_go {add,shift,logical}, o_illegal, o_wb_valid/i/unit, o_busy.
module scalar_issue_scheduler
    import scalar_issue_scheduler_pkg::*;
#(
    parameter int LAT_LOGICAL = DEF_LAT_LOGICAL,
    parameter int LAT_SHIFT   = DEF_LAT_SHIFT,
    parameter int LAT_DSHIFT  = DEF_LAT_DSHIFT,
    parameter int LAT_ADD     = DEF_LAT_ADD,
    parameter int MAX_LAT     = DEF_MAX_LAT
) (
    input  logic                      clk,
    input  logic                      rst,
    scalar_issue_scheduler_if.slave   iss,
    input  logic [7:0]                i_ext_busy,
    output logic                      o_stall_src,
    output logic                      o_stall_dst,
    output logic                      o_stall_port,
    output logic [2:0]                o_fu_go,
    output logic                      o_illegal,
    output logic                      o_wb_valid,
    output logic [2:0]                o_wb_i,
    output logic [1:0]                o_wb_unit,
    output logic [7:0]                o_busy
);

    localparam int LW = $clog2(MAX_LAT + 1);
    localparam int IW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    dec_t              dec;
    logic [LW-1:0]     lat;
    logic [7:0]        busy_q;
    logic [7:0]        res;
    logic [MAX_LAT-1:0] slot_v;
    logic [MAX_LAT:0]  slot_vx;
    wb_slot_t          head;
    wb_slot_t          ins_slot;
    logic              src;
    logic              dst;
    logic              port;
    logic              fire;
    logic              go;
    logic [7:0]        set_mask;
    logic [7:0]        clr_mask;

    assign dec = decode(iss.i_instr, iss.i_j, iss.i_k);

    always_comb begin
        lat = LW'(LAT_LOGICAL);
        unique case (dec.lcls)
            LC_SHF:  lat = LW'(LAT_SHIFT);
            LC_DSHF: lat = LW'(LAT_DSHIFT);
            LC_ADD:  lat = LW'(LAT_ADD);
            default: lat = LW'(LAT_LOGICAL);
        endcase
    end

    assign res = busy_q | i_ext_busy;

    // Top slot index MAX_LAT is never occupied.
    assign slot_vx = {1'b0, slot_v};

    assign src  = (dec.rd_i & res[iss.i_i])
                | (dec.rd_j & res[iss.i_j])
                | (dec.rd_k & res[iss.i_k]);
    assign dst  = dec.claimed & res[iss.i_i];
    assign port = dec.claimed & slot_vx[lat];

    assign o_stall_src  = src;
    assign o_stall_dst  = dst;
    assign o_stall_port = port;

    // Nothing may fire while reset is held.
    assign iss.o_issue_ready = !rst & !(src | dst | port);

    assign fire = iss.i_issue_valid & iss.o_issue_ready;
    assign go   = fire & dec.claimed;

    assign o_fu_go   = go ? (3'b001 << dec.unit) : 3'b000;
    assign o_illegal = fire & !dec.claimed;

    assign ins_slot.v    = 1'b1;
    assign ins_slot.i    = iss.i_i;
    assign ins_slot.unit = dec.unit;

    scalar_wb_chain #(
        .DEPTH (MAX_LAT),
        .IW    (IW)
    ) u_chain (
        .clk      (clk),
        .rst      (rst),
        .ins_en   (go),
        .ins_idx  (IW'(lat - LW'(1))),
        .ins_slot (ins_slot),
        .slot_v   (slot_v),
        .head     (head)
    );

    assign o_wb_valid = head.v & !rst;
    assign o_wb_i     = head.i;
    assign o_wb_unit  = head.unit;

    assign set_mask = go ? (8'b1 << iss.i_i) : 8'b0;
    assign clr_mask = o_wb_valid ? (8'b1 << head.i) : 8'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~clr_mask) | set_mask;
        end
    end

    assign o_busy = busy_q;

endmodule

// File: tb/tb_scalar_issue_scheduler.sv
// Directed, table-driven bench for scalar_issue_scheduler.
// Rows are consecutive cycles; reset-abort sequence is hand-written.
module tb_scalar_issue_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ext_busy;
    logic       stall_src, stall_dst, stall_port;
    logic [2:0] fu_go;
    logic       illegal;
    logic       wb_valid;
    logic [2:0] wb_i;
    logic [1:0] wb_unit;
    logic [7:0] busy;

    scalar_issue_scheduler_if ifc ();

    scalar_issue_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .iss          (ifc),
        .i_ext_busy   (ext_busy),
        .o_stall_src  (stall_src),
        .o_stall_dst  (stall_dst),
        .o_stall_port (stall_port),
        .o_fu_go      (fu_go),
        .o_illegal    (illegal),
        .o_wb_valid   (wb_valid),
        .o_wb_i       (wb_i),
        .o_wb_unit    (wb_unit),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [6:0] op;
        logic [2:0] i;
        logic [2:0] j;
        logic [2:0] k;
        logic [7:0] ext;
        logic       rdy;
        logic       src;
        logic       dst;
        logic       port;
        logic [2:0] go;
        logic       ill;
        logic       wbv;
        logic [2:0] wbi;
        logic [1:0] wbu;
        logic [7:0] busy;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(
        logic v, logic [6:0] op, logic [2:0] i, logic [2:0] j,
        logic [2:0] k, logic [7:0] ext,
        logic rdy, logic src, logic dst, logic port,
        logic [2:0] go, logic ill,
        logic wbv, logic [2:0] wbi, logic [1:0] wbu,
        logic [7:0] bsy);
        return {v, op, i, j, k, ext, rdy, src, dst, port,
                go, ill, wbv, wbi, wbu, bsy};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(logic v, logic [6:0] op, logic [2:0] i,
                         logic [2:0] j, logic [2:0] k, logic [7:0] ext);
        ifc.i_issue_valid = v;
        ifc.i_instr       = op;
        ifc.i_i           = i;
        ifc.i_j           = j;
        ifc.i_k           = k;
        ext_busy          = ext;
    endtask

    function automatic vec_t idle(logic wbv, logic [2:0] wbi,
                                  logic [1:0] wbu, logic [7:0] bsy);
        return mk(0, 7'o000, 0, 0, 0, 8'h00,
                  1, 0, 0, 0, 3'b000, 0, wbv, wbi, wbu, bsy);
    endfunction

    logic [8:0]  ctrl_act, ctrl_exp;
    logic [13:0] st_act, st_exp;

    initial begin
        // c0: state right after reset
        tbl.push_back(idle(0, 0, 0, 8'h00));
        // single logical op, L=1
        tbl.push_back(mk(1, 7'o044, 1, 2, 3, 8'h00,
                         1, 0, 0, 0, 3'b001, 0, 0, 0, 0, 8'h00));
        tbl.push_back(idle(1, 1, 0, 8'h02));
        tbl.push_back(idle(0, 0, 0, 8'h00));
        // add then dependent logical: RAW stall
        tbl.push_back(mk(1, 7'o060, 4, 1, 2, 8'h00,
                         1, 0, 0, 0, 3'b100, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 7'o044, 5, 4, 0, 8'h00,
                         0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 8'h10));
        tbl.push_back(mk(1, 7'o044, 5, 4, 0, 8'h00,
                         0, 1, 0, 1, 3'b000, 0, 0, 0, 0, 8'h10));
        tbl.push_back(mk(1, 7'o044, 5, 4, 0, 8'h00,
                         0, 1, 0, 0, 3'b000, 0, 1, 4, 2, 8'h10));
        tbl.push_back(mk(1, 7'o044, 5, 4, 0, 8'h00,
                         1, 0, 0, 0, 3'b001, 0, 0, 0, 0, 8'h00));
        tbl.push_back(idle(1, 5, 0, 8'h20));
        tbl.push_back(idle(0, 0, 0, 8'h00));
        // write-port collision
        tbl.push_back(mk(1, 7'o060, 1, 0, 0, 8'h00,
                         1, 0, 0, 0, 3'b100, 0, 0, 0, 0, 8'h00));
        tbl.push_back(idle(0, 0, 0, 8'h02));
        tbl.push_back(mk(1, 7'o042, 2, 0, 0, 8'h00,
                         0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 8'h02));
        tbl.push_back(mk(1, 7'o042, 2, 0, 0, 8'h00,
                         1, 0, 0, 0, 3'b001, 0, 1, 1, 2, 8'h02));
        tbl.push_back(idle(1, 2, 0, 8'h04));
        tbl.push_back(idle(0, 0, 0, 8'h00));
        // constants j=0/k=0, then Si reserved
        tbl.push_back(mk(1, 7'o050, 3, 0, 0, 8'h01,
                         1, 0, 0, 0, 3'b001, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 7'o050, 3, 0, 0, 8'h00,
                         0, 1, 1, 0, 3'b000, 0, 1, 3, 0, 8'h08));
        tbl.push_back(mk(1, 7'o050, 3, 0, 0, 8'h08,
                         0, 1, 1, 0, 3'b000, 0, 0, 0, 0, 8'h00));
        tbl.push_back(idle(0, 0, 0, 8'h00));
        // unclaimed opcode, then external reservation on Si
        tbl.push_back(mk(1, 7'o077, 2, 0, 0, 8'h00,
                         1, 0, 0, 0, 3'b000, 1, 0, 0, 0, 8'h00));
        tbl.push_back(idle(0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 7'o051, 7, 1, 2, 8'h80,
                         0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 8'h00));
        tbl.push_back(idle(0, 0, 0, 8'h00));
        // single shift latency 2
        tbl.push_back(mk(1, 7'o055, 1, 0, 0, 8'h00,
                         1, 0, 0, 0, 3'b010, 0, 0, 0, 0, 8'h00));
        tbl.push_back(idle(0, 0, 0, 8'h02));
        tbl.push_back(idle(1, 1, 1, 8'h02));
        tbl.push_back(idle(0, 0, 0, 8'h00));
        // double shift reads Sj
        tbl.push_back(mk(1, 7'o057, 2, 3, 0, 8'h08,
                         0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 8'h00));
        tbl.push_back(idle(0, 0, 0, 8'h00));

        // Reset held with a claimed request pending
        drive(1, 7'o044, 1, 2, 3, 8'h00);
        @(negedge clk);
        chk("rst_go", 32'({fu_go, illegal, wb_valid}), 32'(5'b0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (tbl[n]) begin
            drive(tbl[n].v, tbl[n].op, tbl[n].i, tbl[n].j,
                  tbl[n].k, tbl[n].ext);
            @(negedge clk);
            ctrl_act = {ifc.o_issue_ready,
                        tbl[n].v ? {stall_src, stall_dst, stall_port}
                                 : 3'b000,
                        fu_go, illegal};
            ctrl_exp = {tbl[n].rdy,
                        tbl[n].v ? {tbl[n].src, tbl[n].dst, tbl[n].port}
                                 : 3'b000,
                        tbl[n].go, tbl[n].ill};
            chk($sformatf("row%0d_ctrl", n), 32'(ctrl_act), 32'(ctrl_exp));
            st_act = {wb_valid, wb_valid ? {wb_i, wb_unit} : 5'b0, busy};
            st_exp = {tbl[n].wbv,
                      tbl[n].wbv ? {tbl[n].wbi, tbl[n].wbu} : 5'b0,
                      tbl[n].busy};
            chk($sformatf("row%0d_state", n), 32'(st_act), 32'(st_exp));
            @(posedge clk);
            #1;
        end

        // Double shift in flight, aborted by reset
        drive(1, 7'o056, 6, 0, 0, 8'h00);
        @(negedge clk);
        chk("abort_fire", 32'({ifc.o_issue_ready, fu_go}), 32'(4'b1010));
        @(posedge clk);
        #1;
        drive(0, 7'o000, 0, 0, 0, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy_pre", 32'(busy), 32'(8'h40));
        chk("abort_wb_rst", 32'(wb_valid), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1, 7'o054, 6, 0, 0, 8'h00);
        @(negedge clk);
        chk("abort_busy_post", 32'({busy, wb_valid}), 32'(0));
        chk("abort_accept", 32'({ifc.o_issue_ready, fu_go}), 32'(4'b1010));
        @(posedge clk);
        #1;
        drive(0, 7'o000, 0, 0, 0, 8'h00);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("abort_wb_c%0d", c), 32'(wb_valid),
                32'(c == 1));
            if (c == 1) begin
                chk("abort_wb_dst", 32'({wb_i, wb_unit}),
                    32'({3'd6, 2'd1}));
            end
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
